// File: rtl/sdram_test_reporter.sv
// Buffers SDRAM test records in a small FIFO and prints each as an ASCII hex
// line ("AAAAAA:DDDDDDDD P\r\n") over the uart tx_byte/tx_en/tx_ready handshake.
module sdram_test_reporter #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_DIGITS = 6,
  parameter int unsigned DATA_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic [22:0] rec_addr,
  input  logic [31:0] rec_data,
  input  logic        rec_fail,
  output logic [7:0]  tx_byte,
  output logic        tx_en,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = PW + 1;
  localparam int unsigned AW       = 4 * ADDR_DIGITS;
  localparam int unsigned DW       = 4 * DATA_DIGITS;
  localparam int unsigned LINE_LEN = ADDR_DIGITS + DATA_DIGITS + 5;
  localparam int unsigned IW       = $clog2(LINE_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [22:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic          fifo_fail_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [IW-1:0] char_idx_q, char_idx_d;
  logic [AW-1:0] line_addr_q;
  logic [DW-1:0] line_data_q;
  logic          line_fail_q;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_en_q, tx_en_d;
  logic          overflow_q;

  logic          push, pop;
  logic [7:0]    char_c;
  int unsigned   idx, sh;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // rec_ready comes from the pre-pop count, so a full FIFO rejects even on a pop cycle
  assign rec_ready = (count_q != CW'(DEPTH));
  assign push      = rec_valid && rec_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= rec_addr;
      fifo_data_q[wr_ptr_q] <= rec_data;
      fifo_fail_q[wr_ptr_q] <= rec_fail;
    end
  end

  // Character selected by char_idx within the current line
  always_comb begin
    idx    = 32'(char_idx_q);
    sh     = 0;
    char_c = 8'h0A;
    if (idx < ADDR_DIGITS) begin
      sh     = 4 * (ADDR_DIGITS - 1 - idx);
      char_c = hex_ascii(4'(line_addr_q >> sh));
    end else if (idx == ADDR_DIGITS) begin
      char_c = 8'h3A;
    end else if (idx < ADDR_DIGITS + 1 + DATA_DIGITS) begin
      sh     = 4 * (ADDR_DIGITS + DATA_DIGITS - idx);
      char_c = hex_ascii(4'(line_data_q >> sh));
    end else if (idx == ADDR_DIGITS + DATA_DIGITS + 1) begin
      char_c = 8'h20;
    end else if (idx == ADDR_DIGITS + DATA_DIGITS + 2) begin
      char_c = line_fail_q ? 8'h46 : 8'h50;
    end else if (idx == ADDR_DIGITS + DATA_DIGITS + 3) begin
      char_c = 8'h0D;
    end
  end

  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    tx_en_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          char_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_en_d   = 1'b1;
          tx_byte_d = char_c;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (32'(char_idx_q) == LINE_LEN - 1) begin
          state_d = IDLE;
        end else begin
          char_idx_d = char_idx_q + 1'b1;
          state_d    = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      char_idx_q  <= '0;
      line_addr_q <= '0;
      line_data_q <= '0;
      line_fail_q <= 1'b0;
      tx_byte_q   <= 8'h00;
      tx_en_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        line_addr_q <= AW'(fifo_addr_q[rd_ptr_q]);
        line_data_q <= DW'(fifo_data_q[rd_ptr_q]);
        line_fail_q <= fifo_fail_q[rd_ptr_q];
      end
      count_q    <= count_d;
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_en_q    <= tx_en_d;
      if (rec_valid && !rec_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_en    = tx_en_q;
  assign overflow = overflow_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_sdram_test_reporter.sv
// Randomized and directed bench for sdram_test_reporter: a transaction-level
// model predicts output characters into a scoreboard queue checked by a monitor.
module tb_sdram_test_reporter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_valid;
  logic        rec_ready;
  logic [22:0] rec_addr;
  logic [31:0] rec_data;
  logic        rec_fail;
  logic [7:0]  tx_byte;
  logic        tx_en;
  logic        tx_ready;
  logic        busy;
  logic        overflow;

  always #5 clk = ~clk;

  sdram_test_reporter #(
    .DEPTH(DEPTH),
    .ADDR_DIGITS(6),
    .DATA_DIGITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_addr(rec_addr),
    .rec_data(rec_data),
    .rec_fail(rec_fail),
    .tx_byte(tx_byte),
    .tx_en(tx_en),
    .tx_ready(tx_ready),
    .busy(busy),
    .overflow(overflow)
  );

  typedef struct packed {
    logic [22:0] a;
    logic [31:0] d;
    logic        f;
  } rec_t;

  rec_t       fifo_m[$];
  logic [7:0] line_m[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  bit         cool_m, strobe_m, ovf_m;
  logic [7:0] byte_m;
  bit         mon_on = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_accept = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one at %0t", name, $time);
  endtask

  function automatic string line_text(input rec_t r);
    string s;
    s = $sformatf("%h:%h %s", {1'b0, r.a}, r.d, r.f ? "F" : "P");
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) >= 8'h61 && s.getc(i) <= 8'h66) s.putc(i, s.getc(i) - 8'd32);
    end
    return s;
  endfunction

  // Reference: FIFO of records, queue of characters left in the current line,
  // and a one-cycle cool-down after every character.
  always @(posedge clk) begin
    int    pre;
    rec_t  r;
    string s;
    if (rst) begin
      fifo_m.delete();
      line_m.delete();
      exp_q.delete();
      cool_m   = 1'b0;
      strobe_m = 1'b0;
      ovf_m    = 1'b0;
      byte_m   = 8'h00;
    end else begin
      pre      = fifo_m.size();
      strobe_m = 1'b0;
      if (cool_m) begin
        cool_m = 1'b0;
      end else if (line_m.size() != 0) begin
        if (tx_ready) begin
          strobe_m = 1'b1;
          byte_m   = line_m.pop_front();
          cool_m   = 1'b1;
        end
      end else if (pre != 0) begin
        s = line_text(fifo_m.pop_front());
        for (int i = 0; i < s.len(); i++) line_m.push_back(s.getc(i));
        line_m.push_back(8'h0D);
        line_m.push_back(8'h0A);
      end
      if (rec_valid) begin
        if (pre < DEPTH) begin
          r.a = rec_addr;
          r.d = rec_data;
          r.f = rec_fail;
          fifo_m.push_back(r);
          s = line_text(r);
          for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("tx_en", tx_en, strobe_m);
      chk("tx_byte_hold", tx_byte, byte_m);
      chk("rec_ready", rec_ready, fifo_m.size() < DEPTH);
      chk("busy", busy, (fifo_m.size() != 0) || (line_m.size() != 0) || cool_m);
      chk("overflow", overflow, ovf_m);
      if (tx_en) begin
        rx_log.push_back(tx_byte);
        if (exp_q.size() == 0) fail_to("tx_char_unexpected");
        else chk("tx_char", tx_byte, exp_q.pop_front());
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [22:0] a, input logic [31:0] d, input logic f, input int budget);
    int w;
    rec_addr  = a;
    rec_data  = d;
    rec_fail  = f;
    rec_valid = 1'b1;
    w = 0;
    while (!rec_ready && w < budget) begin
      step;
      w++;
    end
    if (!rec_ready) begin
      fail_to("push_accept");
    end else begin
      n_accept++;
      step;
    end
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while (busy && w < budget) begin
      step;
      w++;
    end
    if (busy) fail_to("wait_idle");
  endtask

  task automatic wait_chars(input int n, input int budget);
    int w;
    w = 0;
    while (rx_log.size() < n && w < budget) begin
      step;
      w++;
    end
    if (rx_log.size() < n) fail_to("wait_chars");
  endtask

  // Control characters are shown as '~' so the line prints on one row
  task automatic chk_line(input string name, input string exp);
    string got;
    got = "";
    foreach (rx_log[i]) got = $sformatf("%s%c", got, (rx_log[i] >= 8'h20) ? rx_log[i] : 8'h7E);
    n_checks++;
    if (got != {exp, "~~"}) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s~~\"", name, got, exp);
    end
    rx_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    rst       = 1'b1;
    rec_valid = 1'b0;
    rec_addr  = '0;
    rec_data  = '0;
    rec_fail  = 1'b0;
    tx_ready  = 1'b1;
    repeat (2) @(posedge clk);
    mon_on = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_rec_ready", rec_ready, 1);
    chk("rst_overflow", overflow, 0);

    // All-zero record and first-strobe latency
    rec_addr = 23'h000000; rec_data = 32'h00000000; rec_fail = 1'b0; rec_valid = 1'b1;
    step;
    rec_valid = 1'b0;
    k = 1;
    while (!tx_en && k < 20) begin
      step;
      k++;
    end
    chk("first_tx_latency", k, 3);
    wait_idle(200);
    chk_line("line_zero", "000000:00000000 P");

    push(23'h7FFFFF, 32'hDEADBEEF, 1'b1, 100);
    rec_valid = 1'b0;
    wait_idle(200);
    chk_line("line_max", "7FFFFF:DEADBEEF F");

    // tx_ready low in the middle of the data digits
    push(23'h012345, 32'h89ABCDEF, 1'b0, 100);
    rec_valid = 1'b0;
    wait_chars(9, 200);
    tx_ready = 1'b0;
    cnt = 0;
    repeat (10) begin
      step;
      if (tx_en) cnt++;
    end
    chk("no_tx_while_not_ready", cnt, 0);
    tx_ready = 1'b1;
    wait_idle(200);
    chk_line("line_stalled", "012345:89ABCDEF P");

    // Reset after the fifth character abandons the line
    push(23'h0ABCDE, 32'h13572468, 1'b1, 100);
    rec_valid = 1'b0;
    wait_chars(5, 200);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_tx_byte", tx_byte, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_rec_ready", rec_ready, 1);
    rx_log.delete();
    cnt = 0;
    repeat (10) begin
      step;
      if (tx_en) cnt++;
    end
    chk("no_tx_after_rst", cnt, 0);
    push(23'h000ABC, 32'h0000FFFF, 1'b0, 100);
    rec_valid = 1'b0;
    wait_idle(200);
    chk_line("line_after_rst", "000ABC:0000FFFF P");

    // Full FIFO: push offered on the same cycle as a pop
    for (int i = 0; i < 5; i++) push(23'(i + 16), 32'(i) * 32'h11111111, 1'(i), 100);
    rec_valid = 1'b0;
    k = 0;
    while (!(line_m.size() == 0 && !cool_m && fifo_m.size() == DEPTH) && k < 300) begin
      step;
      k++;
    end
    if (k >= 300) fail_to("full_idle_window");
    rec_addr = 23'h5A5A5A; rec_data = 32'hCAFEF00D; rec_fail = 1'b1; rec_valid = 1'b1;
    step;
    rec_valid = 1'b0;
    chk("full_pop_push_ready", rec_ready, 1);
    chk("full_pop_push_ovf", overflow, 1);
    wait_idle(1000);
    chk("full_pop_push_lines", rx_log.size(), 5 * 19);
    rx_log.delete();

    // Six records against a stalled uart
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("ovf_clear_by_rst", overflow, 0);
    tx_ready = 1'b0;
    n_accept = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(23'(i * 32'h111), 32'(i) * 32'h01010101, 1'(i), 2000);
        rec_valid = 1'b0;
      end
      begin
        repeat (10) step;
        chk("accepted_while_stalled", n_accept, 5);
        chk("sixth_not_ready", rec_ready, 0);
        chk("overflow_set", overflow, 1);
        tx_ready = 1'b1;
      end
    join
    wait_idle(3000);
    chk("six_lines_out", rx_log.size(), 6 * 19);
    chk("overflow_held", overflow, 1);
    rx_log.delete();

    // Random traffic with random uart back-pressure
    for (int c = 0; c < 3000; c++) begin
      rec_valid = ($urandom_range(0, 29) == 0);
      rec_addr  = 23'($urandom);
      rec_data  = $urandom;
      rec_fail  = 1'($urandom_range(0, 1));
      tx_ready  = ($urandom_range(0, 9) < 7);
      step;
    end
    rec_valid = 1'b0;
    tx_ready  = 1'b1;
    wait_idle(3000);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
